gmux_sel_ctrl: RTL and testbench

Parametrised, glitch-free select controller for a bank of `NUM_CH` global clock muxes, each gated by a per-channel select. It takes channel-switch requests over a valid/ready handshake and sequences them break-before-make. The old select drops, a programmable gap elapses, the new select rises, and a minimum dwell is enforced before the next switch. It sits in the clock-network fabric between configuration or user logic and the gated-select inputs of the global muxes.

---
 rtl/gmux_sel_ctrl.sv | 119 +++++++++++
 tb/tb_gmux_sel_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gmux_sel_ctrl.sv
// gmux_sel_ctrl: break-before-make select sequencer for NUM_CH global clock muxes.
// Define GMUX_SWCNT_EN to add the saturating 16-bit sw_cnt switch counter output.
module gmux_sel_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int GAP    = 4,
  parameter int DWELL  = 8
) (
  input  logic              QCK,
  input  logic              QRT,
  input  logic              req_valid,
  input  logic [CH_W-1:0]   req_ch,
  input  logic              req_en,
  output logic              req_ready,
  output logic [NUM_CH-1:0] IS,
  output logic [CH_W-1:0]   cur_ch,
  output logic              cur_en,
`ifdef GMUX_SWCNT_EN
  output logic [15:0]       sw_cnt,
`endif
  output logic              sel_err
);
  localparam int MX = (GAP > DWELL) ? GAP : DWELL;
  localparam int CW = $clog2(MX) + 1;
  typedef enum logic [1:0] {IDLE, DROP, HOLD} state_t;
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [CH_W-1:0] r_tgt_ch, w_tgt_ch, r_cur_ch, w_cur_ch;
  logic [NUM_CH-1:0] r_is, w_is, w_hot;
  logic r_tgt_en, w_tgt_en, r_cur_en, w_cur_en, r_ready, w_ready, r_err, w_err;
  logic w_acc, w_oor, w_nop;
  assign w_acc = req_valid & r_ready;
  assign w_oor = req_en & (int'(req_ch) >= NUM_CH);
  assign w_nop = req_en ? (req_ch == r_cur_ch && r_cur_en) : !r_cur_en;
  assign w_hot = NUM_CH'(1) << r_tgt_ch;
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_tgt_ch = r_tgt_ch;
    w_tgt_en = r_tgt_en;
    w_cur_ch = r_cur_ch;
    w_cur_en = r_cur_en;
    w_is     = r_is;
    w_ready  = r_ready;
    w_err    = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        w_err   = w_acc & w_oor;
        if (w_acc && !w_oor && !w_nop) begin
          w_state  = DROP;
          w_ready  = 1'b0;
          w_is     = '0;
          w_cnt    = CW'(GAP - 1);
          w_tgt_ch = req_ch;
          w_tgt_en = req_en;
        end
      end
      DROP: begin
        if (r_cnt != '0) w_cnt = r_cnt - CW'(1);
        else if (r_tgt_en) begin
          w_is     = w_hot;
          w_cur_ch = r_tgt_ch;
          w_cur_en = 1'b1;
          w_cnt    = CW'(DWELL - 1);
          w_state  = HOLD;
        end else begin
          w_cur_en = 1'b0;
          w_ready  = 1'b1;
          w_state  = IDLE;
        end
      end
      HOLD: begin
        if (r_cnt != '0) w_cnt = r_cnt - CW'(1);
        else begin
          w_ready = 1'b1;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tgt_ch <= '0;
      r_tgt_en <= 1'b0;
      r_cur_ch <= '0;
      r_cur_en <= 1'b0;
      r_is     <= '0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_tgt_ch <= w_tgt_ch;
      r_tgt_en <= w_tgt_en;
      r_cur_ch <= w_cur_ch;
      r_cur_en <= w_cur_en;
      r_is     <= w_is;
      r_ready  <= w_ready;
      r_err    <= w_err;
    end
  end
`ifdef GMUX_SWCNT_EN
  logic [15:0] r_sw_cnt;
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) r_sw_cnt <= '0;
    else if (r_state == DROP && w_state == HOLD && r_sw_cnt != 16'hFFFF) r_sw_cnt <= r_sw_cnt + 16'd1;
  end
  assign sw_cnt = r_sw_cnt;
`endif
  assign req_ready = r_ready;
  assign IS        = r_is;
  assign cur_ch    = r_cur_ch;
  assign cur_en    = r_cur_en;
  assign sel_err   = r_err;
endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// tb_gmux_sel_ctrl: directed scoreboard bench for gmux_sel_ctrl (NUM_CH=4, CH_W=3, GAP=4, DWELL=8).
module tb_gmux_sel_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_en = 1'b0, req_ready, cur_en, sel_err;
  logic [2:0] req_ch = '0, cur_ch;
  logic [3:0] IS;
`ifdef GMUX_SWCNT_EN
  logic [15:0] sw_cnt;
`endif
  int cyc = 0, e0 = 0, n_chk = 0, n_fail = 0;
  typedef struct {
    int cyc;
    logic [3:0] is;
    logic rdy;
    logic en;
    logic [2:0] ch;
    logic err;
    string tag;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  gmux_sel_ctrl #(.NUM_CH(4), .CH_W(3), .GAP(4), .DWELL(8)) dut (
    .QCK(clk), .QRT(rst), .req_valid(req_valid), .req_ch(req_ch), .req_en(req_en),
    .req_ready(req_ready), .IS(IS), .cur_ch(cur_ch), .cur_en(cur_en),
`ifdef GMUX_SWCNT_EN
    .sw_cnt(sw_cnt),
`endif
    .sel_err(sel_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    n_chk++;
    assert ($countones(IS) <= 1) else begin
      n_fail++;
      $error("FAIL onehot: observed IS=%b required at most one bit", IS);
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      assert (e.cyc == cyc && {IS, req_ready, cur_en, cur_ch, sel_err} === {e.is, e.rdy, e.en, e.ch, e.err}) else begin
        n_fail++;
        $error("FAIL %s @%0d: observed IS/rdy/en/ch/err=%b/%b/%b/%0d/%b required %b/%b/%b/%0d/%b at %0d",
               e.tag, cyc, IS, req_ready, cur_en, cur_ch, sel_err, e.is, e.rdy, e.en, e.ch, e.err, e.cyc);
      end
    end
  end
  task automatic ex(int k, logic [3:0] is, logic rdy, logic en, logic [2:0] ch, logic err, string tag);
    sb.push_back('{e0 + k, is, rdy, en, ch, err, tag});
  endtask
  task automatic go(logic [2:0] ch, logic en);
    @(negedge clk);
    req_valid = 1'b1;
    req_ch = ch;
    req_en = en;
    e0 = cyc + 1;
  endtask
  task automatic stop();
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask
  initial begin
    #3;
    n_chk++;
    assert ({IS, req_ready, cur_en, cur_ch, sel_err} === 10'b0) else begin
      n_fail++;
      $error("FAIL reset: observed %b required 0", {IS, req_ready, cur_en, cur_ch, sel_err});
    end
    @(negedge clk);
    rst = 1'b0;
    e0 = cyc + 1;
    ex(0, 4'b0000, 1, 0, 0, 0, "rdy_after_rst");
    wait_to(e0);
    go(2, 1);
    ex(0, 4'b0000, 0, 0, 0, 0, "t1_drop");
    ex(3, 4'b0000, 0, 0, 0, 0, "t1_gap_end");
    ex(4, 4'b0100, 0, 1, 2, 0, "t1_make");
    ex(11, 4'b0100, 0, 1, 2, 0, "t1_hold_end");
    ex(12, 4'b0100, 1, 1, 2, 0, "t1_ready");
    stop();
    wait_to(e0 + 12);
    go(0, 1);
    ex(0, 4'b0000, 0, 1, 2, 0, "t2_drop");
    ex(3, 4'b0000, 0, 1, 2, 0, "t2_gap_end");
    ex(4, 4'b0001, 0, 1, 0, 0, "t2_make");
    ex(12, 4'b0001, 1, 1, 0, 0, "t2_ready");
    stop();
    wait_to(e0 + 12);
    go(1, 1);
    ex(0, 4'b0000, 0, 1, 0, 0, "t3_drop");
    ex(4, 4'b0010, 0, 1, 1, 0, "t3_make");
    ex(12, 4'b0010, 1, 1, 1, 0, "t3_ready");
    stop();
    wait_to(e0 + 12);
    go(1, 1);
    ex(0, 4'b0010, 1, 1, 1, 0, "t4_noop");
    ex(1, 4'b0010, 1, 1, 1, 0, "t4_noop_after");
    stop();
    wait_to(e0 + 1);
    go(5, 1);
    ex(0, 4'b0010, 1, 1, 1, 1, "t5_err");
    ex(1, 4'b0010, 1, 1, 1, 0, "t5_err_once");
    stop();
    wait_to(e0 + 1);
    go(3, 1);
    ex(4, 4'b1000, 0, 1, 3, 0, "t6_make");
    ex(12, 4'b1000, 1, 1, 3, 0, "t6_ready");
    stop();
    wait_to(e0 + 12);
    go(1, 0);
    ex(0, 4'b0000, 0, 1, 3, 0, "t7_drop");
    ex(3, 4'b0000, 0, 1, 3, 0, "t7_gap_end");
    ex(4, 4'b0000, 1, 0, 3, 0, "t7_desel");
    stop();
    wait_to(e0 + 4);
    go(2, 0);
    ex(0, 4'b0000, 1, 0, 3, 0, "t8_desel_noop");
    ex(1, 4'b0000, 1, 0, 3, 0, "t8_noop_after");
    stop();
    wait_to(e0 + 1);
    go(1, 1);
    ex(4, 4'b0010, 0, 1, 1, 0, "t9_make");
    ex(6, 4'b0010, 0, 1, 1, 0, "t9_hold");
    stop();
    wait_to(e0 + 6);
    #1 rst = 1'b1;
    #1;
    n_chk++;
    assert ({IS, req_ready, cur_en, cur_ch, sel_err} === 10'b0) else begin
      n_fail++;
      $error("FAIL async_rst: observed %b required 0", {IS, req_ready, cur_en, cur_ch, sel_err});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1;
    req_ch = 3'd2;
    req_en = 1'b1;
    e0 = cyc + 2;
    ex(-1, 4'b0000, 1, 0, 0, 0, "t10_rdy_first");
    ex(0, 4'b0000, 0, 0, 0, 0, "t10_accept");
    ex(4, 4'b0100, 0, 1, 2, 0, "t10_make");
    ex(12, 4'b0100, 1, 1, 2, 0, "t10_ready");
    wait_to(e0);
    req_valid = 1'b0;
    wait_to(e0 + 12);
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    n_chk++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: observed %0d pending required 0", sb.size());
    end
`ifdef GMUX_SWCNT_EN
    n_chk++;
    assert (sw_cnt === 16'd1) else begin
      n_fail++;
      $error("FAIL sw_cnt: observed %0d required 1", sw_cnt);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
